// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: start/stop/clear stopwatch counting 00.00-99.99 s in BCD.
// tick_1ms is a clock enable from the divider stage. Every TICKS_PER_COUNT
// ticks in RUN advance the count by 0.01 s.
// Optional lap capture is enabled by defining STOPWATCH_LAP_EN. Without it the
// lap ports stay tied to zero and no lap registers exist.
module stopwatch_bcd #(
    parameter int unsigned TICKS_PER_COUNT = 10,  // 1..255
    parameter int unsigned WRAP            = 1    // 1: roll over, 0: saturate and pause
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        tick_1ms,
    input  logic        btn_start_stop,
    input  logic        btn_clear,
    output logic [3:0]  sec_tens,
    output logic [3:0]  sec_ones,
    output logic [3:0]  tenths,
    output logic [3:0]  hundredths,
    output logic        running,
    output logic        overflow,
    input  logic        btn_lap,
    output logic [15:0] lap_digits,
    output logic        lap_valid
);

    typedef enum logic [1:0] {StIdle, StRun, StPaused} state_e;

    localparam logic [7:0] PrescLast = 8'(TICKS_PER_COUNT - 1);

    state_e     state_q, state_d;
    logic       running_q, running_d;
    logic       ovf_q, ovf_d;
    logic [7:0] presc_q, presc_d;
    logic [3:0] st_q, st_d, so_q, so_d, te_q, te_d, hu_q, hu_d;
    logic       ss_hist_q, clr_hist_q;
    logic       press_ss, press_clr;
    logic       step, at_max;

    // Rising-edge detect on the debounced button levels.
    always_comb begin
        press_ss  = btn_start_stop & ~ss_hist_q;
        press_clr = btn_clear & ~clr_hist_q;
    end

    // Next-state for FSM, prescaler, BCD count and sticky overflow.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        ovf_d   = ovf_q;
        st_d    = st_q;
        so_d    = so_q;
        te_d    = te_q;
        hu_d    = hu_q;
        step    = 1'b0;
        at_max  = (st_q == 4'd9) && (so_q == 4'd9) && (te_q == 4'd9) && (hu_q == 4'd9);

        // Counting looks at the pre-edge state, so a tick alongside a stop press still counts.
        if (state_q == StRun && tick_1ms) begin
            if (presc_q == PrescLast) begin
                presc_d = 8'd0;
                step    = 1'b1;
            end else begin
                presc_d = presc_q + 8'd1;
            end
        end

        if (step) begin
            if (at_max) begin
                ovf_d = 1'b1;
                if (WRAP != 0) begin
                    st_d = 4'd0;
                    so_d = 4'd0;
                    te_d = 4'd0;
                    hu_d = 4'd0;
                end else begin
                    state_d = StPaused;
                end
            end else begin
                hu_d = (hu_q == 4'd9) ? 4'd0 : hu_q + 4'd1;
                if (hu_q == 4'd9) begin
                    te_d = (te_q == 4'd9) ? 4'd0 : te_q + 4'd1;
                    if (te_q == 4'd9) begin
                        so_d = (so_q == 4'd9) ? 4'd0 : so_q + 4'd1;
                        // sec_tens is below 9 here, otherwise at_max would hold.
                        if (so_q == 4'd9) st_d = st_q + 4'd1;
                    end
                end
            end
        end

        if (press_ss) begin
            unique case (state_q)
                StIdle: begin
                    state_d = StRun;
                    presc_d = 8'd0;
                end
                StRun:    state_d = StPaused;
                StPaused: state_d = StRun;  // prescaler kept: partial interval resumes
                default:  state_d = StIdle;
            endcase
        end

        // Clear beats everything else in the same cycle, including start/stop.
        if (press_clr) begin
            state_d = StIdle;
            presc_d = 8'd0;
            ovf_d   = 1'b0;
            st_d    = 4'd0;
            so_d    = 4'd0;
            te_d    = 4'd0;
            hu_d    = 4'd0;
        end

        running_d = (state_d == StRun);
    end

    // State, count and button history registers with synchronous reset.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q    <= StIdle;
            running_q  <= 1'b0;
            ovf_q      <= 1'b0;
            presc_q    <= 8'd0;
            st_q       <= 4'd0;
            so_q       <= 4'd0;
            te_q       <= 4'd0;
            hu_q       <= 4'd0;
            // History forced high so a button held through reset needs a fresh press.
            ss_hist_q  <= 1'b1;
            clr_hist_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            running_q  <= running_d;
            ovf_q      <= ovf_d;
            presc_q    <= presc_d;
            st_q       <= st_d;
            so_q       <= so_d;
            te_q       <= te_d;
            hu_q       <= hu_d;
            ss_hist_q  <= btn_start_stop;
            clr_hist_q <= btn_clear;
        end
    end

    assign sec_tens   = st_q;
    assign sec_ones   = so_q;
    assign tenths     = te_q;
    assign hundredths = hu_q;
    assign running    = running_q;
    assign overflow   = ovf_q;

`ifdef STOPWATCH_LAP_EN
    logic        lap_hist_q;
    logic        press_lap;
    logic [15:0] lap_q, lap_d;
    logic        lap_valid_q, lap_valid_d;

    // Lap snapshot of the pre-edge digits, only while running; clear wins.
    always_comb begin
        press_lap   = btn_lap & ~lap_hist_q;
        lap_d       = lap_q;
        lap_valid_d = lap_valid_q;
        if (press_clr) begin
            lap_d       = 16'd0;
            lap_valid_d = 1'b0;
        end else if (press_lap && state_q == StRun) begin
            lap_d       = {st_q, so_q, te_q, hu_q};
            lap_valid_d = 1'b1;
        end
    end

    // Lap registers with synchronous reset.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            lap_hist_q  <= 1'b1;
            lap_q       <= 16'd0;
            lap_valid_q <= 1'b0;
        end else begin
            lap_hist_q  <= btn_lap;
            lap_q       <= lap_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    assign lap_digits = lap_q;
    assign lap_valid  = lap_valid_q;
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
    assign lap_digits = 16'd0;
    assign lap_valid  = 1'b0;
`endif

endmodule
